// File: rtl/seg_display_pkg.sv
// Shared types, glyph table and FSM encoding for the 7-segment display path.
package seg_display_pkg;

  typedef logic [7:0] seg_pattern_t;
  typedef logic [3:0] hex_nibble_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRACK    = 2'd1,
    ST_CAPTURED = 2'd2
  } scan_state_t;

  // Sentinel for "no active anode found"; truncates to all-ones in narrower fields.
  localparam int SEG_IDX_NONE = -1;

  // Active-low pattern on seg_n[7:1] (a..g) for each hex value.
  function automatic logic [6:0] glyph_of(input hex_nibble_t nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0000010;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b1110010;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_glyph_lookup.sv
// Reverse glyph lookup: 7-bit active-low segment pattern to hex nibble, with miss flag.
module seg_glyph_lookup
  import seg_display_pkg::*;
(
  input  logic [6:0]  pattern_i,
  output hex_nibble_t nibble_o,
  output logic        miss_o
);

  always_comb begin
    nibble_o = '0;
    miss_o   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == glyph_of(4'(i))) begin
        nibble_o = 4'(i);
        miss_o   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Multiplexed 7-segment bus monitor: debounces single-digit patterns, decodes them per digit
// and streams capture events. Define SEG_CAPTURE_SYNC_EN to add a 2-flop input synchronizer.
module seg_scan_capture
  import seg_display_pkg::*;
#(
  parameter  int DIGITS        = 8,
  parameter  int STABLE_CYCLES = 4,
  localparam int IDXW          = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [7:0]            seg_n,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic [DIGITS-1:0]     dp_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [IDXW-1:0]       upd_idx,
  output logic [3:0]            upd_data,
  output logic                  upd_err,
  output logic                  overflow_o,
  output logic                  frame_o
);

  localparam int         SW         = DIGITS + 8;
  localparam logic [7:0] STABLE_C   = 8'(STABLE_CYCLES);
  localparam logic       STABLE_ONE = (STABLE_CYCLES == 1);

  logic [SW-1:0] samp;
  logic [SW-1:0] prev_q;

`ifdef SEG_CAPTURE_SYNC_EN
  logic [SW-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {an_n, seg_n};
      sync2_q <= sync1_q;
    end
  end
  assign samp = sync2_q;
`else
  assign samp = {an_n, seg_n};
`endif

  logic [DIGITS-1:0] samp_act;
  seg_pattern_t      samp_seg;
  logic              samp_valid;
  logic              samp_same;
  logic [IDXW-1:0]   samp_idx;
  hex_nibble_t       lk_nibble;
  logic              lk_miss;

  assign samp_act   = ~samp[SW-1:8];
  assign samp_seg   = samp[7:0];
  assign samp_valid = (samp_act != '0) && ((samp_act & (samp_act - 1'b1)) == '0);
  assign samp_same  = (samp == prev_q);

  always_comb begin
    int first_zero;
    first_zero = SEG_IDX_NONE;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (samp_act[i]) first_zero = i;
    end
    samp_idx = first_zero[IDXW-1:0];
  end

  seg_glyph_lookup u_lookup (
    .pattern_i (samp_seg[7:1]),
    .nibble_o  (lk_nibble),
    .miss_o    (lk_miss)
  );

  scan_state_t state_q;
  logic [7:0]  cnt_q;
  logic [DIGITS-1:0] seen_q;
  logic [DIGITS-1:0] seen_nx;
  logic        capture;

  // A new valid pattern counts as its own first sample, so STABLE_CYCLES=1 captures at once.
  always_comb begin
    capture = 1'b0;
    case (state_q)
      ST_IDLE:     capture = samp_valid && STABLE_ONE;
      ST_TRACK:    capture = samp_valid && (samp_same ? (cnt_q + 8'd1 == STABLE_C) : STABLE_ONE);
      ST_CAPTURED: capture = samp_valid && !samp_same && STABLE_ONE;
      default:     capture = 1'b0;
    endcase
  end

  assign seen_nx = seen_q | samp_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      seen_q     <= '0;
      digits_o   <= '0;
      dp_o       <= '0;
      err_o      <= '0;
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      upd_data   <= '0;
      upd_err    <= 1'b0;
      overflow_o <= 1'b0;
      frame_o    <= 1'b0;
    end else begin
      prev_q  <= samp;
      frame_o <= 1'b0;
      if (upd_valid && upd_ready) upd_valid <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (samp_valid) begin
            cnt_q   <= 8'd1;
            state_q <= capture ? ST_CAPTURED : ST_TRACK;
          end else begin
            cnt_q <= '0;
          end
        end
        ST_TRACK: begin
          if (!samp_valid) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (!samp_same) begin
            cnt_q   <= 8'd1;
            state_q <= capture ? ST_CAPTURED : ST_TRACK;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (capture) state_q <= ST_CAPTURED;
          end
        end
        ST_CAPTURED: begin
          if (!samp_same) begin
            if (samp_valid) begin
              cnt_q   <= 8'd1;
              state_q <= capture ? ST_CAPTURED : ST_TRACK;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase

      if (capture) begin
        digits_o[{samp_idx, 2'b00} +: 4] <= lk_nibble;
        dp_o[samp_idx]  <= ~samp_seg[0];
        err_o[samp_idx] <= lk_miss;
        // Digit registers always update; only the stream event can be lost.
        if (!upd_valid || upd_ready) begin
          upd_valid <= 1'b1;
          upd_idx   <= samp_idx;
          upd_data  <= lk_nibble;
          upd_err   <= lk_miss;
        end else begin
          overflow_o <= 1'b1;
        end
        if (seen_nx == '1) begin
          frame_o <= 1'b1;
          seen_q  <= '0;
        end else begin
          seen_q <= seen_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed self-checking bench for seg_scan_capture (default build, DIGITS=8, STABLE_CYCLES=4).
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  an_n;
  logic [7:0]  seg_n;
  logic [31:0] digits_o;
  logic [7:0]  dp_o;
  logic [7:0]  err_o;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_idx;
  logic [3:0]  upd_data;
  logic        upd_err;
  logic        overflow_o;
  logic        frame_o;

  int checks = 0;
  int errors = 0;

  seg_scan_capture #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .digits_o   (digits_o),
    .dp_o       (dp_o),
    .err_o      (err_o),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_idx    (upd_idx),
    .upd_data   (upd_data),
    .upd_err    (upd_err),
    .overflow_o (overflow_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // seg_n bytes for 0..7 with the decimal point off
  logic [7:0] seg_tbl [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};

  logic [31:0] snap_digits;
  logic [7:0]  snap_dp, snap_err;

  initial begin
    rst_n = 1'b0; an_n = 8'hFF; seg_n = 8'hFF; upd_ready = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_digits", digits_o, 0);
    chk("rst_dp", dp_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_valid", upd_valid, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_frame", frame_o, 0);

    // digit 0 shows '0', dp off: capture on edge E+3
    an_n = 8'hFE; seg_n = 8'h03;
    cyc(3);
    chk("d0_not_yet", upd_valid, 0);
    cyc(1);
    chk("d0_valid", upd_valid, 1);
    chk("d0_idx", upd_idx, 0);
    chk("d0_data", upd_data, 0);
    chk("d0_err", upd_err, 0);
    chk("d0_nib", digits_o[3:0], 0);
    chk("d0_dp", dp_o[0], 0);
    upd_ready = 1'b1;
    cyc(1);
    chk("d0_accept", upd_valid, 0);

    // digit 2 'F': 3 cycles is not enough, 4 is
    an_n = 8'hFF; cyc(2);
    an_n = 8'hFB; seg_n = 8'h71; cyc(3);
    an_n = 8'hFF; cyc(2);
    chk("d2_short_valid", upd_valid, 0);
    chk("d2_short_nib", digits_o[11:8], 0);
    an_n = 8'hFB; seg_n = 8'h71; cyc(4);
    chk("d2_nib", digits_o[11:8], 4'hF);
    chk("d2_valid", upd_valid, 1);
    chk("d2_idx", upd_idx, 2);
    chk("d2_data", upd_data, 4'hF);
    chk("d2_dp", dp_o[2], 0);
    an_n = 8'hFF; cyc(2);

    // two anodes low: never a capture
    snap_digits = digits_o; snap_dp = dp_o; snap_err = err_o;
    an_n = 8'hFC; seg_n = 8'h9E; cyc(10);
    chk("multi_digits", digits_o, snap_digits);
    chk("multi_dp", dp_o, snap_dp);
    chk("multi_err", err_o, snap_err);
    chk("multi_valid", upd_valid, 0);
    an_n = 8'hFF; cyc(1);

    // stalled consumer: second event dropped, overflow sticky
    upd_ready = 1'b0;
    an_n = 8'hFD; seg_n = 8'h9E; cyc(4);
    chk("st1_valid", upd_valid, 1);
    chk("st1_idx", upd_idx, 1);
    chk("st1_data", upd_data, 1);
    chk("st1_dp", dp_o[1], 1);
    an_n = 8'hFF; cyc(1);
    an_n = 8'hF7; seg_n = 8'h0D; cyc(4);
    chk("st2_idx_held", upd_idx, 1);
    chk("st2_data_held", upd_data, 1);
    chk("st2_ovf", overflow_o, 1);
    chk("st2_nib3", digits_o[15:12], 3);
    upd_ready = 1'b1;
    an_n = 8'hFF; cyc(1);
    chk("st_drain", upd_valid, 0);
    chk("st_ovf_sticky", overflow_o, 1);

    // fresh reset, then full scan 0..7
    @(negedge clk); rst_n = 1'b0; cyc(1); rst_n = 1'b1; cyc(1);
    for (int d = 0; d < 8; d++) begin
      an_n = ~(8'h01 << d); seg_n = seg_tbl[d];
      cyc(4);
      chk($sformatf("scan%0d_nib", d), digits_o[4*d +: 4], 4'(d));
      chk($sformatf("scan%0d_frame", d), frame_o, (d == 7) ? 1 : 0);
    end
    cyc(1);
    chk("frame_one_cycle", frame_o, 0);
    an_n = 8'hFE; seg_n = 8'h03; cyc(4);
    chk("seen_cleared", frame_o, 0);

    // dp-only pattern on digit 5: glyph miss
    an_n = 8'hDF; seg_n = 8'hFE; cyc(4);
    chk("miss_err5", err_o[5], 1);
    chk("miss_nib5", digits_o[23:20], 0);
    chk("miss_dp5", dp_o[5], 1);
    chk("miss_upd_err", upd_err, 1);
    chk("miss_idx", upd_idx, 5);

    // asynchronous reset mid-TRACK
    an_n = 8'hFB; seg_n = 8'h03; cyc(2);
    rst_n = 1'b0; #1;
    chk("arst_digits", digits_o, 0);
    chk("arst_dp", dp_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_valid", upd_valid, 0);
    chk("arst_ovf", overflow_o, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
